router_pkt_fifo: RTL and testbench

//  Parametrised packet-aware FIFO for the router output path; one instance per destination port.

---
 rtl/router_pkg.sv | 16 +
 rtl/router_pkt_counter.sv | 52 +++++
 rtl/router_pkt_fifo.sv | 123 ++++++++++++
 tb/tb_router_pkt_fifo.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants and types for the router packet FIFO and its packet counter.
package router_pkg;

  // Default byte width on the router data path.
  localparam int DATA_W_DEF = 8;

  // Header byte layout: length field occupies d[DATA_W-1:HDR_LEN_LSB].
  localparam int HDR_LEN_LSB = 2;

  // One stored FIFO entry at the default width: header flag above the data byte.
  typedef struct packed {
    logic       hdr;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/router_pkt_counter.sv
// Tracks bytes remaining in the packet being read out and flags the final (parity) byte.
module router_pkt_counter
  import router_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  localparam int LW     = DATA_W - HDR_LEN_LSB,
  // One bit wider than the length field so that a maximum-length header's
  // length + 1 (payload plus parity) is held without wrapping to zero.
  localparam int RW     = LW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic          pop,
  input  logic          hdr,
  input  logic [LW-1:0] len,
  output logic          pkt_last
);

  logic [RW-1:0] rem_reg;
  logic [RW-1:0] rem_next;
  logic          last_reg;
  logic          last_next;

  // Next remaining count and last-byte flag for the byte being popped this cycle.
  always_comb begin
    rem_next  = rem_reg;
    last_next = 1'b0;
    if (pop) begin
      if (hdr) begin
        rem_next = RW'(len) + RW'(1);
      end else if (rem_reg != '0) begin
        rem_next  = rem_reg - RW'(1);
        last_next = (rem_reg == RW'(1));
      end
    end
  end

  // Register the count; reset or flush discards any partial packet.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      rem_reg  <= '0;
      last_reg <= 1'b0;
    end else begin
      rem_reg  <= rem_next;
      last_reg <= last_next;
    end
  end

  assign pkt_last = last_reg;

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware FIFO for one router output port: header-tagged storage,
// registered read data with valid/last qualifiers, fill status and error pulses.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = 16,
  parameter  int AF_LVL = 14,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] d_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] d_out,
  output logic              d_valid,
  output logic              pkt_last,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [AW:0]       level,
  output logic              wr_overflow,
  output logic              rd_underflow
);

  localparam logic [AW:0] AF_THR = (AW+1)'(AF_LVL);

  logic [DATA_W:0]   mem [DEPTH];
  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;
  logic              hdr_reg;
  logic [DATA_W-1:0] d_out_reg;
  logic              d_valid_reg;
  logic              wr_overflow_reg;
  logic              rd_underflow_reg;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W:0]   rd_entry;

  // Status is derived purely from the pointers; flush cycles accept nothing.
  always_comb begin
    empty       = (wr_ptr_reg == rd_ptr_reg);
    full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    level       = wr_ptr_reg - rd_ptr_reg;
    almost_full = (level >= AF_THR);
    wr_acc      = write_enb && !full && !soft_reset;
    rd_acc      = read_enb && !empty && !soft_reset;
    rd_entry    = mem[rd_ptr_reg[AW-1:0]];
  end

  // Storage array: single write port, contents survive reset.
  always_ff @(posedge clk) begin
    if (resetn && wr_acc) begin
      mem[wr_ptr_reg[AW-1:0]] <= {hdr_reg, d_in};
    end
  end

  // Header tag is the FSM load-first-data state delayed by one cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hdr_reg <= 1'b0;
    end else begin
      hdr_reg <= lfd_state;
    end
  end

  // Pointer advance; both reset kinds return the FIFO to empty.
  always_ff @(posedge clk) begin
    if (!resetn || soft_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_acc) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Registered read data and valid; d_out holds across idle and flush cycles.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      d_out_reg   <= '0;
      d_valid_reg <= 1'b0;
    end else if (soft_reset) begin
      d_valid_reg <= 1'b0;
    end else begin
      d_valid_reg <= rd_acc;
      if (rd_acc) d_out_reg <= rd_entry[DATA_W-1:0];
    end
  end

  // Single-cycle error pulses for blocked requests, muted during a flush.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_overflow_reg  <= 1'b0;
      rd_underflow_reg <= 1'b0;
    end else begin
      wr_overflow_reg  <= write_enb && full && !soft_reset;
      rd_underflow_reg <= read_enb && empty && !soft_reset;
    end
  end

  router_pkt_counter #(
    .DATA_W (DATA_W)
  ) u_counter (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (soft_reset),
    .pop      (rd_acc),
    .hdr      (rd_entry[DATA_W]),
    .len      (rd_entry[DATA_W-1:HDR_LEN_LSB]),
    .pkt_last (pkt_last)
  );

  assign d_out        = d_out_reg;
  assign d_valid      = d_valid_reg;
  assign wr_overflow  = wr_overflow_reg;
  assign rd_underflow = rd_underflow_reg;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed self-checking bench for router_pkt_fifo (default parameters).
module tb_router_pkt_fifo;
  import router_pkg::*;

  logic       clk = 1'b0;
  logic       resetn, soft_reset, write_enb, lfd_state, read_enb;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_valid, pkt_last, empty, full, almost_full;
  logic [4:0] level;
  logic       wr_overflow, rd_underflow;

  int n_vec = 0;
  int n_err = 0;

  router_pkt_fifo #(.DATA_W(8), .DEPTH(16), .AF_LVL(14)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .soft_reset   (soft_reset),
    .write_enb    (write_enb),
    .lfd_state    (lfd_state),
    .d_in         (d_in),
    .read_enb     (read_enb),
    .d_out        (d_out),
    .d_valid      (d_valid),
    .pkt_last     (pkt_last),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .level        (level),
    .wr_overflow  (wr_overflow),
    .rd_underflow (rd_underflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; outputs are settled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write one byte; a header byte is preceded by a cycle of lfd_state.
  task automatic push(input logic [7:0] b, input logic is_hdr);
    if (is_hdr) begin
      lfd_state = 1'b1;
      tick();
      lfd_state = 1'b0;
    end
    write_enb = 1'b1;
    d_in      = b;
    tick();
    write_enb = 1'b0;
  endtask

  // Read one byte and check data/valid/last on the following cycle.
  task automatic pop(input string tag, input logic [7:0] exp_d, input logic exp_last);
    read_enb = 1'b1;
    tick();
    read_enb = 1'b0;
    check_val({tag, ".valid"}, 32'(d_valid), 32'd1);
    check_val({tag, ".data"}, 32'(d_out), 32'(exp_d));
    check_val({tag, ".last"}, 32'(pkt_last), 32'(exp_last));
  endtask

  initial begin
    logic [7:0] hdr_b;
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
    read_enb = 1'b0; d_in = 8'h00;

    // T1 reset
    tick(); tick();
    check_val("t1.empty", 32'(empty), 32'd1);
    check_val("t1.full", 32'(full), 32'd0);
    check_val("t1.level", 32'(level), 32'd0);
    check_val("t1.d_out", 32'(d_out), 32'd0);
    check_val("t1.d_valid", 32'(d_valid), 32'd0);
    resetn = 1'b1;
    tick();

    // T2 one packet: header len 3, three payload bytes, parity
    push(8'h0C, 1'b1);
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    push(8'h44, 1'b0);
    check_val("t2.level", 32'(level), 32'd5);
    pop("t2.hdr", 8'h0C, 1'b0);
    pop("t2.p0", 8'h11, 1'b0);
    pop("t2.p1", 8'h22, 1'b0);
    pop("t2.p2", 8'h33, 1'b0);
    pop("t2.par", 8'h44, 1'b1);
    tick();
    check_val("t2.idle_valid", 32'(d_valid), 32'd0);
    check_val("t2.idle_hold", 32'(d_out), 32'h44);
    check_val("t2.empty", 32'(empty), 32'd1);

    // T3 fill to full, overflow, drain; three rounds to wrap the pointers
    for (int r = 0; r < 3; r++) begin
      write_enb = 1'b1;
      for (int i = 0; i < 16; i++) begin
        d_in = 8'(r * 16 + i);
        tick();
        check_val($sformatf("t3.r%0d.af%0d", r, i + 1), 32'(almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
      end
      check_val($sformatf("t3.r%0d.full", r), 32'(full), 32'd1);
      d_in = 8'hFF;
      tick();
      write_enb = 1'b0;
      check_val($sformatf("t3.r%0d.ovf", r), 32'(wr_overflow), 32'd1);
      check_val($sformatf("t3.r%0d.lvl16", r), 32'(level), 32'd16);
      tick();
      check_val($sformatf("t3.r%0d.ovf_clr", r), 32'(wr_overflow), 32'd0);
      read_enb = 1'b1;
      for (int i = 0; i < 16; i++) begin
        tick();
        check_val($sformatf("t3.r%0d.rd%0d", r, i), 32'(d_out), 32'(r * 16 + i));
        check_val($sformatf("t3.r%0d.v%0d", r, i), 32'(d_valid), 32'd1);
      end
      read_enb = 1'b0;
      check_val($sformatf("t3.r%0d.empty", r), 32'(empty), 32'd1);
      tick();
    end

    // T4 simultaneous read/write at level 5, then at empty
    for (int i = 0; i < 5; i++) push(8'(8'hA0 + i), 1'b0);
    read_enb = 1'b1; write_enb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_in = 8'(8'hB0 + i);
      tick();
      check_val($sformatf("t4.lvl%0d", i), 32'(level), 32'd5);
      check_val($sformatf("t4.rd%0d", i), 32'(d_out), 32'(8'hA0 + i));
    end
    read_enb = 1'b0; write_enb = 1'b0;
    pop("t4.a4", 8'hA4, 1'b0);
    for (int i = 0; i < 4; i++) pop($sformatf("t4.b%0d", i), 8'(8'hB0 + i), 1'b0);
    check_val("t4.empty", 32'(empty), 32'd1);
    read_enb = 1'b1; write_enb = 1'b1; d_in = 8'hC0;
    tick();
    read_enb = 1'b0; write_enb = 1'b0;
    check_val("t4.e_valid", 32'(d_valid), 32'd0);
    check_val("t4.e_level", 32'(level), 32'd1);
    check_val("t4.e_unf", 32'(rd_underflow), 32'd1);
    pop("t4.c0", 8'hC0, 1'b0);

    // T5 soft_reset in the middle of a length-10 packet
    hdr_b = 8'(10 << HDR_LEN_LSB);
    push(hdr_b, 1'b1);
    for (int i = 0; i < 5; i++) push(8'(8'hD0 + i), 1'b0);
    pop("t5.hdr", hdr_b, 1'b0);
    for (int i = 0; i < 3; i++) pop($sformatf("t5.p%0d", i), 8'(8'hD0 + i), 1'b0);
    soft_reset = 1'b1; write_enb = 1'b1; d_in = 8'hEE;
    tick();
    soft_reset = 1'b0; write_enb = 1'b0;
    check_val("t5.empty", 32'(empty), 32'd1);
    check_val("t5.level", 32'(level), 32'd0);
    check_val("t5.valid", 32'(d_valid), 32'd0);
    check_val("t5.last", 32'(pkt_last), 32'd0);
    check_val("t5.hold", 32'(d_out), 32'hD2);
    push(8'h00, 1'b1);
    push(8'h5A, 1'b0);
    pop("t5.n_hdr", 8'h00, 1'b0);
    pop("t5.n_par", 8'h5A, 1'b1);

    // T6 underflow leaves the read pointer alone
    read_enb = 1'b1;
    tick();
    read_enb = 1'b0;
    check_val("t6.unf", 32'(rd_underflow), 32'd1);
    check_val("t6.valid", 32'(d_valid), 32'd0);
    check_val("t6.level", 32'(level), 32'd0);
    tick();
    check_val("t6.unf_clr", 32'(rd_underflow), 32'd0);
    push(8'h77, 1'b0);
    check_val("t6.level1", 32'(level), 32'd1);
    pop("t6.after", 8'h77, 1'b0);
    check_val("t6.empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
